// File: rtl/uart_word_tx.sv
// Word-to-byte serializer in front of async_transmitter: FIFO-buffered words leave LSB byte first.
// Define UART_WORD_TX_CSUM_EN to append an XOR checksum byte after every word.
module uart_word_tx #(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [8*WORD_BYTES-1:0]       wr_data,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  input  logic                          tx_busy,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int DW = 8 * WORD_BYTES;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX_C = IW'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_GAP   = 3'd3,
    S_DRAIN = 3'd4
`ifdef UART_WORD_TX_CSUM_EN
    , S_CSUM = 3'd5
`endif
  } state_t;

  state_t          state_r, next_s;
  logic [DW-1:0]   mem_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [7:0]      word_r [WORD_BYTES];
  logic [IW-1:0]   idx_r;
  logic [7:0]      tx_data_r;
  logic [7:0]      byte_s;
  logic            tx_start_s;
  logic            push_s;
  logic            pop_s;

`ifdef UART_WORD_TX_CSUM_EN
  logic [7:0]      acc_r;
  logic            csum_sent_r;

  function automatic logic [7:0] xor_byte(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // A full FIFO refuses writes even when a pop lands in the same cycle.
  assign wr_ready   = (count_r < DEPTH_C);
  assign push_s     = wr_valid && wr_ready;
  assign fifo_count = count_r;
  assign busy       = (state_r != S_IDLE) || (count_r != '0);
  assign tx_start   = tx_start_s;
  assign tx_data    = tx_start_s ? byte_s : tx_data_r;

  // Word FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= next_s;
  end

  // FSM next-state logic; GAP skips one busy sample to cover transmitter latency.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE:  if (count_r != '0) next_s = S_LOAD; else next_s = S_IDLE;
      S_LOAD:  next_s = S_START;
      S_START: if (!tx_busy) next_s = S_GAP; else next_s = S_START;
      S_GAP:   next_s = S_DRAIN;
      S_DRAIN: begin
        if (tx_busy)                  next_s = S_DRAIN;
        else if (idx_r != LAST_IDX_C) next_s = S_START;
`ifdef UART_WORD_TX_CSUM_EN
        else if (!csum_sent_r)        next_s = S_CSUM;
`endif
        else                          next_s = S_IDLE;
      end
`ifdef UART_WORD_TX_CSUM_EN
      S_CSUM:  if (!tx_busy) next_s = S_GAP; else next_s = S_CSUM;
`endif
      default: next_s = S_IDLE;
    endcase
  end

  // FSM outputs: start pulse, selected byte and FIFO pop.
  always_comb begin
    tx_start_s = 1'b0;
    byte_s     = word_r[idx_r];
    pop_s      = (state_r == S_LOAD);
    case (state_r)
      S_START: if (!tx_busy) tx_start_s = 1'b1; else tx_start_s = 1'b0;
`ifdef UART_WORD_TX_CSUM_EN
      S_CSUM: begin
        byte_s = acc_r;
        if (!tx_busy) tx_start_s = 1'b1; else tx_start_s = 1'b0;
      end
`endif
      default: tx_start_s = 1'b0;
    endcase
  end

  // Shift register, byte index, held output byte and checksum accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r     <= '0;
      tx_data_r <= 8'h00;
      for (int b = 0; b < WORD_BYTES; b++) word_r[b] <= 8'h00;
`ifdef UART_WORD_TX_CSUM_EN
      acc_r       <= 8'h00;
      csum_sent_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_LOAD: begin
          for (int b = 0; b < WORD_BYTES; b++) word_r[b] <= mem_r[rd_ptr_r][8*b +: 8];
          idx_r <= '0;
`ifdef UART_WORD_TX_CSUM_EN
          acc_r       <= 8'h00;
          csum_sent_r <= 1'b0;
`endif
        end
        S_DRAIN: if (!tx_busy && (idx_r != LAST_IDX_C)) idx_r <= idx_r + 1'b1;
        default: idx_r <= idx_r;
      endcase
      if (tx_start_s) tx_data_r <= byte_s;
`ifdef UART_WORD_TX_CSUM_EN
      if (tx_start_s && (state_r == S_START)) acc_r <= xor_byte(acc_r, byte_s);
      if (tx_start_s && (state_r == S_CSUM))  csum_sent_r <= 1'b1;
`endif
    end
  end

endmodule
